// File: rtl/kypd_emulator_if.sv
// Signal bundle between a keypad scanner (master side) and the keypad
// emulator (slave side): column strobes in, row lines and status out.
interface kypd_emulator_if;
    logic [3:0] Col;        // active-low one-hot column strobe from the scanner
    logic [3:0] Row;        // active-low emulated row lines, 1111 = no key
    logic [3:0] key_in;     // hex code of the key to press
    logic       press_req;  // request to press key_in
    logic       busy;       // press/release sequence in progress
    logic       done;       // one-cycle completion pulse

    modport master (
        output Col,
        output key_in,
        output press_req,
        input  Row,
        input  busy,
        input  done
    );

    modport slave (
        input  Col,
        input  key_in,
        input  press_req,
        output Row,
        output busy,
        output done
    );
endinterface

// File: rtl/kypd_emulator.sv
// Keypad emulator: pretends a single key of a 4x4 hex keypad is held down
// for HOLD_CYCLES clocks, then released for RELEASE_CYCLES clocks. While the
// key is down, the matching row line is pulled low one clock after the
// scanner strobes the key's column, exactly as a real switch matrix would
// appear to a scanner that samples a few cycles after strobing.
module kypd_emulator #(
    parameter logic [31:0] HOLD_CYCLES    = 32'd25000000,
    parameter logic [31:0] RELEASE_CYCLES = 32'd6250000
) (
    input  logic             clk,
    input  logic             rst,
    kypd_emulator_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Column strobe pattern (active-low one-hot) for a key on the keypad:
    //   C1: 1 4 7 0   C2: 2 5 8 F   C3: 3 6 9 E   C4: A B C D
    function automatic logic [3:0] key_col_pat(input logic [3:0] key);
        logic [3:0] pat;
        case (key)
            4'h1, 4'h4, 4'h7, 4'h0: pat = 4'b0111;
            4'h2, 4'h5, 4'h8, 4'hF: pat = 4'b1011;
            4'h3, 4'h6, 4'h9, 4'hE: pat = 4'b1101;
            4'hA, 4'hB, 4'hC, 4'hD: pat = 4'b1110;
            default:                pat = 4'b1111;
        endcase
        return pat;
    endfunction

    // Row line pattern (active-low one-hot) for a key on the keypad:
    //   R1: 1 2 3 A   R2: 4 5 6 B   R3: 7 8 9 C   R4: 0 F E D
    function automatic logic [3:0] key_row_pat(input logic [3:0] key);
        logic [3:0] pat;
        case (key)
            4'h1, 4'h2, 4'h3, 4'hA: pat = 4'b0111;
            4'h4, 4'h5, 4'h6, 4'hB: pat = 4'b1011;
            4'h7, 4'h8, 4'h9, 4'hC: pat = 4'b1101;
            4'h0, 4'hF, 4'hE, 4'hD: pat = 4'b1110;
            default:                pat = 4'b1111;
        endcase
        return pat;
    endfunction

    // Counters stop at the terminal value, so the compare values are the
    // last cycle index of each phase.
    localparam logic [31:0] HOLD_LAST_C    = HOLD_CYCLES - 32'd1;
    localparam logic [31:0] RELEASE_LAST_C = RELEASE_CYCLES - 32'd1;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_nxt_s;
    logic [3:0]  key_r;
    logic [3:0]  key_nxt_s;
    logic [3:0]  row_r;
    logic [3:0]  row_nxt_s;
    logic        busy_r;
    logic        busy_nxt_s;
    logic        done_r;
    logic        done_nxt_s;
    logic        col_hit_s;

    // Key is seen as closed only when the scanner drives exactly this
    // key's column; 0000, 1111 and multi-zero strobes never match a
    // one-hot pattern.
    assign col_hit_s = (bus.Col == key_col_pat(key_r));

    // Next-state, counter, key latch and next-output decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        key_nxt_s   = key_r;
        done_nxt_s  = 1'b0;
        row_nxt_s   = 4'b1111;

        case (state_r)
            ST_IDLE: begin
                if (bus.press_req) begin
                    key_nxt_s   = bus.key_in;
                    cnt_nxt_s   = 32'd0;
                    state_nxt_s = ST_PRESS;
                end else begin
                    cnt_nxt_s   = 32'd0;
                end
            end
            ST_PRESS: begin
                if (cnt_r == HOLD_LAST_C) begin
                    cnt_nxt_s   = 32'd0;
                    state_nxt_s = ST_RELEASE;
                end else begin
                    cnt_nxt_s   = cnt_r + 32'd1;
                end
            end
            ST_RELEASE: begin
                if (cnt_r == RELEASE_LAST_C) begin
                    cnt_nxt_s   = 32'd0;
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + 32'd1;
                end
            end
            default: begin
                cnt_nxt_s   = 32'd0;
                key_nxt_s   = 4'h0;
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Row follows the column strobe of the current cycle, but only while
        // the key is held down.
        if ((state_r == ST_PRESS) && col_hit_s) begin
            row_nxt_s = key_row_pat(key_r);
        end else begin
            row_nxt_s = 4'b1111;
        end

        // busy covers every PRESS and RELEASE cycle; the done cycle is IDLE.
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, counter and latched key registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 32'd0;
            key_r   <= 4'h0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            key_r   <= key_nxt_s;
        end
    end

    // Registered outputs to the scanner and the requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r  <= 4'b1111;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            row_r  <= row_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign bus.Row  = row_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_kypd_emulator.sv
// Bench for kypd_emulator with HOLD_CYCLES=20, RELEASE_CYCLES=10.
// A timeline model (cycles elapsed since acceptance plus a keypad layout
// lookup) predicts Row/busy/done every cycle; directed scenarios add
// hand-computed literal expectations.
module tb_kypd_emulator;

    localparam int H = 20;
    localparam int R = 10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    kypd_emulator_if bus ();

    kypd_emulator #(
        .HOLD_CYCLES    (32'd20),
        .RELEASE_CYCLES (32'd10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] layout [4][4];   // layout[row][col] = key code
    logic [3:0] colseq [4];
    logic       m_active;
    int         m_age;           // 1..H = held, H+1..H+R = released, H+R+1 = done
    logic [3:0] m_key;
    logic [3:0] e_row;
    logic       e_busy;
    logic       e_done;

    function automatic logic [3:0] m_pat(input logic [3:0] k, input bit want_col);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (layout[r][c] == k)
                    return 4'b1111 ^ (4'b1000 >> (want_col ? c : r));
        return 4'b1111;
    endfunction

    initial begin
        layout[0][0] = 4'h1; layout[0][1] = 4'h2; layout[0][2] = 4'h3; layout[0][3] = 4'hA;
        layout[1][0] = 4'h4; layout[1][1] = 4'h5; layout[1][2] = 4'h6; layout[1][3] = 4'hB;
        layout[2][0] = 4'h7; layout[2][1] = 4'h8; layout[2][2] = 4'h9; layout[2][3] = 4'hC;
        layout[3][0] = 4'h0; layout[3][1] = 4'hF; layout[3][2] = 4'hE; layout[3][3] = 4'hD;
        colseq[0] = 4'b0111; colseq[1] = 4'b1011; colseq[2] = 4'b1101; colseq[3] = 4'b1110;
    end

    // Model update at each edge, then compare the DUT shortly after it.
    always @(posedge clk) begin
        logic m_idle;
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_key = 4'h0;
            e_row = 4'b1111; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            if (m_active && m_age >= 1 && m_age <= H && bus.Col == m_pat(m_key, 1'b1))
                e_row = m_pat(m_key, 1'b0);
            else
                e_row = 4'b1111;
            m_idle = !m_active || (m_age == H + R + 1);
            if (m_idle && bus.press_req) begin
                m_active = 1'b1; m_age = 1; m_key = bus.key_in;
            end else if (m_active) begin
                if (m_age == H + R + 1) m_active = 1'b0;
                else m_age++;
            end
            e_busy = m_active && (m_age <= H + R);
            e_done = m_active && (m_age == H + R + 1);
        end
        #1;
        chk("model_row",  32'(bus.Row),  32'(e_row));
        chk("model_busy", 32'(bus.busy), 32'(e_busy));
        chk("model_done", 32'(bus.done), 32'(e_done));
    end

    // ---------------- directed scenarios ----------------
    logic [3:0] exp_col [16];
    logic [3:0] exp_row [16];

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        chk(name, 32'(got), 32'd1);
    endtask

    initial begin
        int   k_done;
        int   n1011;
        int   ndone;
        int   n0111;
        int   n1101;
        int   last;
        bit   seen;
        bit   got;
        logic [3:0] prev_col;
        logic [3:0] obs_col;
        logic [3:0] obs_row;

        exp_col = '{4'b0111, 4'b0111, 4'b1011, 4'b1101, 4'b0111, 4'b1011, 4'b1101, 4'b0111,
                    4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1011};
        exp_row = '{4'b1110, 4'b0111, 4'b0111, 4'b0111, 4'b1011, 4'b1011, 4'b1011, 4'b1101,
                    4'b1101, 4'b1101, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1110};
        total = 0; bad = 0;
        rst = 1'b1; bus.Col = 4'b1111; bus.key_in = 4'h0; bus.press_req = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_row",  32'(bus.Row),  32'hF);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Key 5 with a cycling column strobe
        bus.key_in = 4'h5; bus.press_req = 1'b1;
        @(negedge clk);
        bus.press_req = 1'b0;
        chk("k5_busy_after_accept", 32'(bus.busy), 32'd1);
        k_done = 0; n1011 = 0;
        for (int k = 1; k <= 40 && k_done == 0; k++) begin
            if (bus.Row == 4'b1011) n1011++;
            if (bus.done) k_done = k;
            bus.Col = colseq[k % 4];
            @(negedge clk);
        end
        chk("k5_done_latency", 32'(k_done), 32'd31);
        chk("k5_row_hits", 32'(n1011), 32'd5);
        bus.Col = 4'b1111;

        // All 16 keys with a scanning column model
        for (int key = 0; key < 16; key++) begin
            @(negedge clk);
            bus.key_in = 4'(key); bus.press_req = 1'b1; bus.Col = 4'b1111;
            @(negedge clk);
            bus.press_req = 1'b0;
            seen = 1'b0; got = 1'b0; prev_col = 4'b1111; obs_col = 4'b1111; obs_row = 4'b1111;
            for (int c = 1; c <= 40 && !got; c++) begin
                if (!seen && bus.Row != 4'b1111) begin
                    seen = 1'b1; obs_col = prev_col; obs_row = bus.Row;
                end
                if (bus.done) got = 1'b1;
                bus.Col = colseq[c % 4];
                prev_col = bus.Col;
                @(negedge clk);
            end
            chk($sformatf("scan_col_key%0h", key), 32'(obs_col), 32'(exp_col[key]));
            chk($sformatf("scan_row_key%0h", key), 32'(obs_row), 32'(exp_row[key]));
            chk($sformatf("scan_done_key%0h", key), 32'(got), 32'd1);
            bus.Col = 4'b1111;
        end

        // Press request for key 9 while key 1 is held: ignored
        @(negedge clk);
        bus.key_in = 4'h1; bus.press_req = 1'b1;
        @(negedge clk);
        bus.press_req = 1'b0;
        ndone = 0; n0111 = 0; n1101 = 0;
        for (int c = 1; c <= 45; c++) begin
            if (bus.done) ndone++;
            if (bus.Row == 4'b0111) n0111++;
            if (bus.Row == 4'b1101) n1101++;
            if (c >= 5 && c <= 10) begin
                bus.press_req = 1'b1; bus.key_in = 4'h9;
            end else begin
                bus.press_req = 1'b0; bus.key_in = 4'h0;
            end
            bus.Col = colseq[c % 4];
            @(negedge clk);
        end
        chk("busy_ign_done_count", 32'(ndone), 32'd1);
        chk("busy_ign_key9_rows", 32'(n1101), 32'd0);
        chk("busy_ign_key1_rows", 32'(n0111), 32'd5);
        bus.Col = 4'b1111;

        // press_req held high with key A: back-to-back sequences
        bus.key_in = 4'hA; bus.press_req = 1'b1;
        @(negedge clk);
        ndone = 0; last = 0;
        for (int c = 1; c <= 95; c++) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1) chk("b2b_first_done", 32'(c), 32'd31);
                else chk("b2b_gap", 32'(c - last), 32'd31);
                last = c;
            end
            bus.Col = colseq[c % 4];
            @(negedge clk);
        end
        chk("b2b_done_count", 32'(ndone), 32'd3);
        bus.press_req = 1'b0; bus.Col = 4'b1111;
        wait_done("b2b_tail_done");

        // Reset at PRESS cycle 7 of key 7, with a competing press request
        @(negedge clk);
        bus.key_in = 4'h7; bus.press_req = 1'b1; bus.Col = 4'b0111;
        @(negedge clk);
        bus.press_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_row_before", 32'(bus.Row),  32'hD);
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1; bus.press_req = 1'b1; bus.key_in = 4'h2;
        @(negedge clk);
        rst = 1'b0; bus.press_req = 1'b0;
        chk("abort_row",  32'(bus.Row),  32'hF);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        bus.Col = 4'b1111;

        // Illegal column strobes while key 3 is held
        bus.key_in = 4'h3; bus.press_req = 1'b1;
        @(negedge clk);
        bus.press_req = 1'b0; bus.Col = 4'b0000;
        @(negedge clk);
        chk("col_0000_row", 32'(bus.Row), 32'hF);
        bus.Col = 4'b1111;
        @(negedge clk);
        chk("col_1111_row", 32'(bus.Row), 32'hF);
        bus.Col = 4'b1101;
        @(negedge clk);
        chk("col_c3_row", 32'(bus.Row), 32'h7);
        bus.Col = 4'b1001;
        @(negedge clk);
        chk("col_two_low_row", 32'(bus.Row), 32'hF);
        bus.Col = 4'b1111;
        wait_done("k3_done");

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
